rx_descrambler: RTL and testbench

//  802.11a RX descrambler: pops Viterbi-decoded bits from the upstream RX bit FIFO (1-bit, async-read),

---
 rtl/rx_descrambler_pkg.sv | 31 +++
 rtl/rx_descrambler_if.sv | 34 +++
 rtl/rx_descrambler_lfsr7.sv | 50 +++++
 rtl/rx_descrambler.sv | 181 ++++++++++++++++++
 tb/tb_rx_descrambler.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_descrambler_pkg.sv
// -----------------------------------------------------------------------------
// rx_descrambler_pkg
// Shared definitions for the 802.11a RX descrambler: FSM state encoding, frame
// field lengths, LFSR geometry and the scrambler feedback function.
// No ports (package).
// -----------------------------------------------------------------------------
package rx_descrambler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEED = 2'd1,
      ST_SVC  = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   // First SEED_LEN SERVICE bits load the LFSR; SERVICE ends after SVC_LEN bits.
   localparam int SEED_LEN = 7;
   localparam int SVC_LEN  = 16;
   // Shortest frame that still carries one DATA bit.
   localparam int MIN_BITS = SVC_LEN + 1;

   // x^7 + x^4 + 1 with s[6] the oldest bit.
   localparam int LFSR_W = 7;
   localparam int TAP_A  = 6;
   localparam int TAP_B  = 3;

   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return s[TAP_A] ^ s[TAP_B];
   endfunction

endpackage

// File: rtl/rx_descrambler_if.sv
// -----------------------------------------------------------------------------
// rx_descrambler_if
// Bit-stream bus of the descrambler: the pop side towards the upstream 1-bit
// async-read FIFO and the valid/ready side towards the downstream consumer.
//   fifo_data   FIFO read data (valid while fifo_rd_en=1 and !fifo_empty)
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read enable, one bit consumed per edge where it is 1
//   ready       downstream ready
//   data        descrambled bit
//   valid       data valid
//   last        final bit of the frame (with valid)
// master: the descrambler.  slave: the FIFO/consumer environment.
// -----------------------------------------------------------------------------
interface rx_descrambler_if;

   logic fifo_data;
   logic fifo_empty;
   logic fifo_rd_en;
   logic ready;
   logic data;
   logic valid;
   logic last;

   modport master (
      input  fifo_data, fifo_empty, ready,
      output fifo_rd_en, data, valid, last
   );

   modport slave (
      output fifo_data, fifo_empty, ready,
      input  fifo_rd_en, data, valid, last
   );

endinterface

// File: rtl/rx_descrambler_lfsr7.sv
// -----------------------------------------------------------------------------
// rx_descrambler_lfsr7
// 7-bit descrambler LFSR. Either shifts in a received bit (seed recovery) or
// advances on its own feedback (descrambling).
//   iClk    clock, rising edge
//   iRst    asynchronous active-high reset, clears state
//   iClr    synchronous clear to zero (frame start), wins over iEn
//   iEn     shift one position this cycle
//   iLoad   1: shift in iBit, 0: shift in feedback
//   iBit    received bit used while loading
//   oFb     current feedback s[6]^s[3]
//   oState  current register contents
// -----------------------------------------------------------------------------
module rx_descrambler_lfsr7
   import rx_descrambler_pkg::*;
(
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iClr,
   input  logic              iEn,
   input  logic              iLoad,
   input  logic              iBit,
   output logic              oFb,
   output logic [LFSR_W-1:0] oState
);

   logic [LFSR_W-1:0] s_q;
   logic [LFSR_W-1:0] s_d;

   assign oFb    = lfsr_fb(s_q);
   assign oState = s_q;

   always_comb begin
      s_d = s_q;
      if (iClr) begin
         s_d = '0;
      end else if (iEn) begin
         s_d = {s_q[LFSR_W-2:0], (iLoad ? iBit : oFb)};
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

endmodule

// File: rtl/rx_descrambler.sv
// -----------------------------------------------------------------------------
// rx_descrambler
// 802.11a RX descrambler. Pops Viterbi-decoded bits from the RX bit FIFO,
// recovers the scrambler state from the first 7 SERVICE bits, descrambles the
// rest with x^7+x^4+1 and streams the PSDU bits out with valid/ready.
//   iClk      clock, rising edge
//   iRst      asynchronous active-high reset
//   iStart    frame start pulse, accepted only while oBusy=0
//   iNumBits  total frame bits incl. 16 SERVICE bits, latched on start
//   bus       FIFO pop side + output stream (rx_descrambler_if.master)
//   oBusy     frame in progress or final bit not yet handed over
//   oDone     one-cycle pulse on the handshake of the final bit
//   oSeed     recovered scrambler state after SEED, held until next start
//   oSvcErr   sticky per frame: a descrambled SERVICE bit 7..15 was 1
// -----------------------------------------------------------------------------
module rx_descrambler
   import rx_descrambler_pkg::*;
#(
   parameter int LEN_WIDTH   = 16,
   parameter bit OUT_SERVICE = 1'b0
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iStart,
   input  logic [LEN_WIDTH-1:0] iNumBits,
   rx_descrambler_if.master     bus,
   output logic                 oBusy,
   output logic                 oDone,
   output logic [LFSR_W-1:0]    oSeed,
   output logic                 oSvcErr
);

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0] last_idx_q, last_idx_d;
   logic                 data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic [LFSR_W-1:0]    seed_q, seed_d;
   logic                 svc_err_q, svc_err_d;

   logic                 pop;
   logic                 fwd;
   logic                 busy;
   logic                 start_acc;
   logic                 cnt_at_last;
   logic                 out_bit;
   logic                 lfsr_load;
   logic                 lfsr_fb_w;
   logic [LFSR_W-1:0]    lfsr_state;
   logic [LEN_WIDTH-1:0] num_last;

   rx_descrambler_lfsr7 u_lfsr (
      .iClk   (iClk),
      .iRst   (iRst),
      .iClr   (start_acc),
      .iEn    (pop),
      .iLoad  (lfsr_load),
      .iBit   (bus.fifo_data),
      .oFb    (lfsr_fb_w),
      .oState (lfsr_state)
   );

   // Busy covers the tail where the FSM is back in IDLE but the final bit is
   // still waiting in the output register for ready.
   assign busy        = (state_q != ST_IDLE) || valid_q;
   assign start_acc   = iStart && !busy;
   assign cnt_at_last = (cnt_q == last_idx_q);

   // Short frames are stretched so DATA always carries at least one bit.
   assign num_last = (iNumBits < LEN_WIDTH'(MIN_BITS)) ? LEN_WIDTH'(MIN_BITS - 1)
                                                      : iNumBits - LEN_WIDTH'(1);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_acc)                                   state_d = ST_SEED;
         ST_SEED: if (pop && (cnt_q == LEN_WIDTH'(SEED_LEN - 1)))   state_d = ST_SVC;
         ST_SVC:  if (pop && (cnt_q == LEN_WIDTH'(SVC_LEN - 1)))    state_d = ST_DATA;
         ST_DATA: if (pop && cnt_at_last)                          state_d = ST_IDLE;
         default:                                                  state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM outputs
   // The pop decision depends only on state and flags so the FIFO sees a
   // read enable that never loops back through its own data.
   always_comb begin
      pop       = 1'b0;
      lfsr_load = 1'b0;
      fwd       = 1'b0;
      if (state_q != ST_IDLE) begin
         pop = !bus.fifo_empty && (!valid_q || bus.ready);
      end
      lfsr_load = (state_q == ST_SEED);
      fwd       = pop && ((state_q == ST_DATA) || OUT_SERVICE);
   end

   // Seed bits carry no payload, so they forward as 0.
   assign out_bit = lfsr_load ? 1'b0 : (bus.fifo_data ^ lfsr_fb_w);

   // ---------------------------------------------------------------- datapath
   always_comb begin
      cnt_d      = cnt_q;
      last_idx_d = last_idx_q;
      data_d     = data_q;
      valid_d    = valid_q;
      last_d     = last_q;
      seed_d     = seed_q;
      svc_err_d  = svc_err_q;

      if (start_acc) begin
         cnt_d      = '0;
         last_idx_d = num_last;
         svc_err_d  = 1'b0;
      end else if (pop && !cnt_at_last) begin
         cnt_d = cnt_q + LEN_WIDTH'(1);
      end

      // Capture the register value the LFSR will hold after the last seed bit.
      if (pop && (state_q == ST_SEED) && (cnt_q == LEN_WIDTH'(SEED_LEN - 1))) begin
         seed_d = {lfsr_state[LFSR_W-2:0], bus.fifo_data};
      end

      if (pop && (state_q == ST_SVC) && out_bit) begin
         svc_err_d = 1'b1;
      end

      // Output register: a new bit may only land when the old one is gone,
      // which the pop condition already guarantees.
      if (fwd) begin
         data_d  = out_bit;
         valid_d = 1'b1;
         last_d  = cnt_at_last;
      end else if (valid_q && bus.ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cnt_q      <= '0;
         last_idx_q <= '0;
         data_q     <= 1'b0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         seed_q     <= '0;
         svc_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         last_idx_q <= last_idx_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         last_q     <= last_d;
         seed_q     <= seed_d;
         svc_err_q  <= svc_err_d;
      end
   end

   assign bus.fifo_rd_en = pop;
   assign bus.data       = data_q;
   assign bus.valid      = valid_q;
   assign bus.last       = last_q;

   assign oBusy   = busy;
   assign oDone   = valid_q && last_q && bus.ready;
   assign oSeed   = seed_q;
   assign oSvcErr = svc_err_q;

endmodule

// File: tb/tb_rx_descrambler.sv
// -----------------------------------------------------------------------------
// tb_rx_descrambler
// Directed bench for rx_descrambler: a small FIFO model fed with an 802.11a
// scrambled all-zero frame (scrambler seed 1111111), optional bit flips,
// starvation and random back-pressure.
// -----------------------------------------------------------------------------
module tb_rx_descrambler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_bits;
   logic        busy;
   logic        done;
   logic [6:0]  seed;
   logic        svc_err;

   int checks   = 0;
   int failures = 0;

   rx_descrambler_if bus ();

   rx_descrambler #(
      .LEN_WIDTH   (16),
      .OUT_SERVICE (1'b0)
   ) dut (
      .iClk     (clk),
      .iRst     (rst),
      .iStart   (start),
      .iNumBits (num_bits),
      .bus      (bus),
      .oBusy    (busy),
      .oDone    (done),
      .oSeed    (seed),
      .oSvcErr  (svc_err)
   );

   always #5 clk = ~clk;

   // FIFO model
   logic mem [0:511];
   int   wr_cnt = 0;
   int   rd_ptr = 0;
   logic starve = 1'b0;
   logic flush  = 1'b0;

   assign bus.fifo_empty = (rd_ptr >= wr_cnt) || starve;
   assign bus.fifo_data  = mem[rd_ptr[8:0]];

   always @(posedge clk) begin
      if (flush)               rd_ptr <= wr_cnt;
      else if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
   end

   // Output monitor
   logic cap      [0:511];
   logic cap_last [0:511];
   int   n_cap      = 0;
   int   done_cnt   = 0;
   int   empty_viol = 0;

   always @(posedge clk) begin
      if (bus.fifo_rd_en && bus.fifo_empty) empty_viol <= empty_viol + 1;
      if (bus.valid && bus.ready) begin
         cap[n_cap[8:0]]      <= bus.data;
         cap_last[n_cap[8:0]] <= bus.last;
         n_cap                <= n_cap + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scrambles an all-zero payload with seed 1111111 and appends it to the FIFO;
   // bit index flip (if >= 0) is inverted to model a channel error.
   task automatic fill_frame(input int n, input int flip);
      logic [6:0] s;
      logic       fb;
      s = 7'h7f;
      for (int i = 0; i < n; i++) begin
         fb = s[6] ^ s[3];
         s  = {s[5:0], fb};
         mem[wr_cnt + i] = fb ^ (i == flip);
      end
      wr_cnt = wr_cnt + n;
   endtask

   function automatic logic [31:0] cap_vec(input int base, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[k] = cap[base + k];
      return v;
   endfunction

   function automatic logic [31:0] last_vec(input int base, input int n);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[k] = cap_last[base + k];
      return v;
   endfunction

   task automatic run_frame(input int nb, input bit rnd_ready, input bit starve_en,
                            input int restart_at, output int cyc, output bit timed_out);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      num_bits  = 16'(nb);
      start     = 1'b1;
      bus.ready = 1'b1;
      starve    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (done_cnt == d0 && cyc < 2000) begin
         if (rnd_ready) bus.ready = 1'($urandom_range(0, 1));
         if (starve_en) starve = ~starve;
         start = (cyc == restart_at);
         if (cyc == restart_at) num_bits = 16'd40;
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      timed_out = (done_cnt == d0);
      bus.ready = 1'b1;
      starve    = 1'b0;
   endtask

   initial begin
      int base;
      int cyc;
      int d0;
      bit to;

      rst       = 1'b1;
      start     = 1'b0;
      num_bits  = '0;
      bus.ready = 1'b1;
      for (int i = 0; i < 512; i++) mem[i] = 1'b0;

      // Reset state, with a frame already waiting in the FIFO
      repeat (3) @(negedge clk);
      fill_frame(40, -1);
      @(negedge clk);
      check("rst_valid",   32'(bus.valid),      32'd0);
      check("rst_data",    32'(bus.data),       32'd0);
      check("rst_last",    32'(bus.last),       32'd0);
      check("rst_rden",    32'(bus.fifo_rd_en), 32'd0);
      check("rst_busy",    32'(busy),           32'd0);
      check("rst_seed",    32'(seed),           32'd0);
      check("rst_svcerr",  32'(svc_err),        32'd0);
      check("rst_done",    32'(done),           32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_rden",   32'(bus.fifo_rd_en), 32'd0);

      // T1: clean frame, 24 zero PSDU bits at full throughput
      base = n_cap;
      d0   = done_cnt;
      run_frame(40, 1'b0, 1'b0, -1, cyc, to);
      check("t1_timeout", 32'(to),                   32'd0);
      check("t1_cycles",  32'(cyc),                  32'd41);
      check("t1_count",   32'(n_cap - base),         32'd24);
      check("t1_data",    cap_vec(base, 24),         32'h0000_0000);
      check("t1_last",    last_vec(base, 24),        32'h0080_0000);
      check("t1_seed",    32'(seed),                 32'h07);
      check("t1_svcerr",  32'(svc_err),              32'd0);
      repeat (3) @(negedge clk);
      check("t1_done",    32'(done_cnt - d0),        32'd1);
      check("t1_busy",    32'(busy),                 32'd0);
      check("t1_count2",  32'(n_cap - base),         32'd24);

      // T2: frame bit 20 flipped -> PSDU output index 4 only
      fill_frame(40, 20);
      base = n_cap;
      run_frame(40, 1'b0, 1'b0, -1, cyc, to);
      check("t2_timeout", 32'(to),                   32'd0);
      check("t2_count",   32'(n_cap - base),         32'd24);
      check("t2_data",    cap_vec(base, 24),         32'h0000_0010);
      check("t2_svcerr",  32'(svc_err),              32'd0);

      // T3: starved FIFO, random back-pressure
      fill_frame(40, -1);
      base = n_cap;
      run_frame(40, 1'b1, 1'b1, -1, cyc, to);
      check("t3_timeout", 32'(to),                   32'd0);
      check("t3_count",   32'(n_cap - base),         32'd24);
      check("t3_data",    cap_vec(base, 24),         32'h0000_0000);
      check("t3_last",    last_vec(base, 24),        32'h0080_0000);
      check("t3_rden_empty", 32'(empty_viol),        32'd0);
      check("t3_fifo_used",  32'(wr_cnt - rd_ptr),   32'd0);

      // T4: SERVICE bit 10 corrupted
      fill_frame(40, 10);
      base = n_cap;
      run_frame(40, 1'b0, 1'b0, -1, cyc, to);
      check("t4_timeout", 32'(to),                   32'd0);
      check("t4_count",   32'(n_cap - base),         32'd24);
      check("t4_data",    cap_vec(base, 24),         32'h0000_0000);
      check("t4_svcerr",  32'(svc_err),              32'd1);
      repeat (2) @(negedge clk);
      check("t4_svcerr_hold", 32'(svc_err),          32'd1);

      // T5: reset in the middle of DATA, then a clean rerun
      fill_frame(40, -1);
      @(negedge clk);
      num_bits = 16'd40;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t5_svcerr_clr", 32'(svc_err),           32'd0);
      repeat (23) @(negedge clk);
      check("t5_mid_valid",  32'(bus.valid),         32'd1);
      check("t5_mid_busy",   32'(busy),              32'd1);
      rst = 1'b1;
      #1;
      check("t5_rst_valid",  32'(bus.valid),         32'd0);
      check("t5_rst_rden",   32'(bus.fifo_rd_en),    32'd0);
      check("t5_rst_busy",   32'(busy),              32'd0);
      check("t5_rst_seed",   32'(seed),              32'd0);
      check("t5_rst_last",   32'(bus.last),          32'd0);
      @(negedge clk);
      rst   = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("t5_idle_rden",  32'(bus.fifo_rd_en),    32'd0);
      fill_frame(40, -1);
      base = n_cap;
      run_frame(40, 1'b0, 1'b0, -1, cyc, to);
      check("t5_timeout",    32'(to),                32'd0);
      check("t5_count",      32'(n_cap - base),      32'd24);
      check("t5_data",       cap_vec(base, 24),      32'h0000_0000);
      check("t5_last",       last_vec(base, 24),     32'h0080_0000);
      check("t5_seed",       32'(seed),              32'h07);

      // T6: iNumBits=5 clamps to 17; a start while busy is ignored
      fill_frame(17, -1);
      base = n_cap;
      d0   = done_cnt;
      run_frame(5, 1'b0, 1'b0, 5, cyc, to);
      check("t6_timeout",    32'(to),                32'd0);
      check("t6_cycles",     32'(cyc),               32'd18);
      check("t6_data",       32'(cap[base]),         32'd0);
      check("t6_last",       32'(cap_last[base]),    32'd1);
      repeat (4) @(negedge clk);
      check("t6_count",      32'(n_cap - base),      32'd1);
      check("t6_done",       32'(done_cnt - d0),     32'd1);
      check("t6_busy",       32'(busy),              32'd0);
      check("t6_fifo_used",  32'(wr_cnt - rd_ptr),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
